// File: rtl/serial_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_arbiter_if
// Brief   : Requester bus and serial-line status bundle for serial_frame_arbiter.
// Revision: 1.0  initial release
// ============================================================================
interface serial_frame_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int GNT_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx;
    logic                 busy;
    logic [GNT_W-1:0]     grant_id;
    logic                 frame_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx, busy, grant_id, frame_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx, busy, grant_id, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : serial_frame_arbiter
// Brief   : Round-robin arbiter serializing one byte per frame onto a shared tx line.
// Revision: 1.0  initial release
// ============================================================================
module serial_frame_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter int IDLE_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_frame_arbiter_if.slave  bus
);
    localparam int c_GNT_W      = $clog2(NUM_REQ);
    localparam int c_GAP_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int c_CNT_MAX    = (CLKS_PER_BIT > c_GAP_CYCLES) ? CLKS_PER_BIT : c_GAP_CYCLES;
    localparam int c_CNT_W      = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_BIT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((c_GAP_CYCLES > 0) ? c_GAP_CYCLES - 1 : 0);
    localparam logic [c_GNT_W-1:0] c_LAST_REQ = c_GNT_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t               r_state, w_state_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [2:0]           r_bit, w_bit_next;
    logic [7:0]           r_shift, w_shift_next;
    logic                 r_tx, w_tx_next;
    logic [c_GNT_W-1:0]   r_grant, r_ptr;
    logic [c_GNT_W-1:0]   w_winner, w_idx;
    logic                 w_found, w_xfer, w_phase_last;
    logic [7:0]           w_bytes [NUM_REQ];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_bytes[g] = bus.req_data[8*g +: 8];
        end
    endgenerate

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_GNT_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_xfer = (r_state == S_IDLE) && w_found;

    always_comb begin
        bus.req_ready = '0;
        if (w_xfer && !reset) begin
            bus.req_ready[w_winner] = 1'b1;
        end
    end

    assign w_phase_last = (r_cnt == c_BIT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = w_xfer ? w_bytes[w_winner] : r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                if (w_phase_last) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_bit_next   = 3'd0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_phase_last) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_phase_last) begin
                    w_cnt_next   = '0;
                    w_state_next = (IDLE_BITS > 0) ? S_GAP : S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // tx is registered from the upcoming state so the line tracks the FSM without lag.
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[w_bit_next];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (w_xfer) begin
                r_grant <= w_winner;
                r_ptr   <= (w_winner == c_LAST_REQ) ? '0 : w_winner + 1'b1;
            end
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.grant_id   = r_grant;
    assign bus.frame_done = (r_state == S_STOP) && w_phase_last;
endmodule
`default_nettype wire
